load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the CPU request/response handshake and the data-memory port of the
// load/store unit. The LSU uses the slave modport; the CPU/memory side uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;

  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  mem_we, mem_waddr, mem_raddr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output mem_we, mem_waddr, mem_raddr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: byte/halfword/word loads and stores against a 1-cycle
// registered-read memory. Define LSU_MISALIGN_CHECK_EN to fault misaligned accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; latches it on accept
// READ    | memory read address presented
// DATA    | read data valid; load extract or sub-word merge + write
// WRITE   | full-word store written
// RESP    | one-cycle completion pulse
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  if (MEM_SIZE == 0) begin : g_size_check
    $error("load_store_unit: MEM_SIZE must be nonzero");
  end

  logic [2:0]  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;

  logic        req_legal;
  logic        req_misaligned;
  logic [31:0] req_addr_eff;
  logic [1:0]  req_size;

  always_comb begin
    req_size     = bus.req_funct3[1:0];
    req_addr_eff = bus.req_addr;
    if (bus.req_we)
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    else
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
`ifdef LSU_MISALIGN_CHECK_EN
    req_misaligned = req_legal &&
                     (((req_size == 2'b01) && bus.req_addr[0]) ||
                      ((req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
`else
    // Misaligned accesses are silently aligned down to their natural boundary.
    req_misaligned = 1'b0;
    if (req_size == 2'b01)
      req_addr_eff[0] = 1'b0;
    else if (req_size == 2'b10)
      req_addr_eff[1:0] = 2'b00;
`endif
  end

  logic [4:0]  lane_shift;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;
  logic [31:0] store_mask;
  logic [31:0] store_merged;

  always_comb begin
    lane_shift    = {addr_q[1:0], 3'b000};
    rdata_shifted = bus.mem_rdata >> lane_shift;
    case (funct3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
    store_mask   = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    store_merged = (bus.mem_rdata & ~store_mask) | ((wdata_q << lane_shift) & store_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= req_addr_eff;
            wdata_q  <= bus.req_wdata;
            if (!req_legal || req_misaligned) begin
              state        <= S_RESP;
              rdata_q      <= 32'd0;
              misaligned_q <= req_misaligned;
            end else if (bus.req_we && (req_size == 2'b10)) begin
              state <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: state <= S_DATA;
        S_DATA: begin
          state        <= S_RESP;
          rdata_q      <= we_q ? 32'd0 : load_data;
          misaligned_q <= 1'b0;
        end
        S_WRITE: begin
          state        <= S_RESP;
          rdata_q      <= 32'd0;
          misaligned_q <= 1'b0;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = (state == S_IDLE);
  assign bus.resp_valid      = (state == S_RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_misaligned = misaligned_q;

  assign bus.mem_we    = (state == S_WRITE) || ((state == S_DATA) && we_q);
  assign bus.mem_raddr = {addr_q[31:2], 2'b00};
  assign bus.mem_waddr = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = (state == S_WRITE) ? wdata_q : store_merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random loads/stores against a word-array
// reference model, plus reset-during-operation.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if mif ();
  load_store_unit #(.MEM_SIZE(1024)) dut (.clk(clk), .rst(rst), .bus(mif));

  // Responder memory: registered read, write-first on same word.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mif.mem_we) mem[mif.mem_waddr[9:2]] <= mif.mem_wdata;
    if (mif.mem_we && (mif.mem_waddr[9:2] == mif.mem_raddr[9:2]))
      mif.mem_rdata <= mif.mem_wdata;
    else
      mif.mem_rdata <= mem[mif.mem_raddr[9:2]];
  end

  logic [31:0] ref_mem [0:255];
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    bit legal, mis, ready_bad;
    logic [31:0] eaddr, old, neww, rd, sh, mask, got_rd, got_waddr, got_wdata;
    int lat, wecyc, lane, n_resp, n_we, resp_cyc, we_cyc, got_mis;
    // reference model
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = 0; eaddr = addr;
    if (legal && f3[1:0] == 2'd1 && addr[0]) begin
`ifdef LSU_MISALIGN_CHECK_EN
      mis = 1;
`else
      eaddr = addr - (addr % 2);
`endif
    end
    if (legal && f3[1:0] == 2'd2 && addr[1:0] != 0) begin
`ifdef LSU_MISALIGN_CHECK_EN
      mis = 1;
`else
      eaddr = addr - (addr % 4);
`endif
    end
    lane = eaddr % 4;
    old = ref_mem[(eaddr / 4) % 256];
    sh = old >> (8 * lane);
    rd = 0; neww = old; wecyc = 0;
    if (!legal || mis) lat = 1;
    else if (we && f3 == 3'd2) begin lat = 2; wecyc = 1; neww = wd; end
    else if (we) begin
      lat = 3; wecyc = 2;
      mask = (f3 == 3'd1 ? 32'hFFFF : 32'hFF) << (8 * lane);
      neww = (old & ~mask) | ((wd << (8 * lane)) & mask);
    end else begin
      lat = 3;
      case (f3)
        3'd0: rd = 32'($signed(sh[7:0]));
        3'd1: rd = 32'($signed(sh[15:0]));
        3'd4: rd = sh & 32'hFF;
        3'd5: rd = sh & 32'hFFFF;
        default: rd = old;
      endcase
    end
    // drive and observe
    @(posedge clk); #1;
    mif.req_valid = 1; mif.req_we = we; mif.req_funct3 = f3;
    mif.req_addr = addr; mif.req_wdata = wd;
    check({tag, " ready_idle"}, 32'(mif.req_ready), 32'd1);
    @(posedge clk); #1;
    mif.req_valid = 0; mif.req_we = 1'($urandom); mif.req_funct3 = 3'($urandom);
    mif.req_addr = $urandom; mif.req_wdata = $urandom;
    n_resp = 0; n_we = 0; resp_cyc = 0; we_cyc = 0; ready_bad = 0;
    got_rd = 'x; got_mis = -1; got_waddr = 0; got_wdata = 0;
    for (int c = 1; c <= 5; c++) begin
      if (mif.resp_valid) begin
        n_resp++; resp_cyc = c; got_rd = mif.resp_rdata; got_mis = int'(mif.resp_misaligned);
      end
      if (mif.mem_we) begin
        n_we++; we_cyc = c; got_waddr = mif.mem_waddr; got_wdata = mif.mem_wdata;
      end
      if (c <= lat && mif.req_ready) ready_bad = 1;
      @(posedge clk); #1;
    end
    check({tag, " resp_count"}, n_resp, 1);
    check({tag, " resp_cycle"}, resp_cyc, lat);
    check({tag, " rdata"}, got_rd, rd);
    check({tag, " misaligned"}, got_mis, int'(mis));
    check({tag, " busy_ready"}, 32'(ready_bad), 32'd0);
    check({tag, " we_count"}, n_we, (wecyc != 0) ? 1 : 0);
    if (wecyc != 0) begin
      check({tag, " we_cycle"}, we_cyc, wecyc);
      check({tag, " waddr"}, got_waddr, {eaddr[31:2], 2'b00});
      check({tag, " wdata"}, got_wdata, neww);
      ref_mem[(eaddr / 4) % 256] = neww;
    end
    check({tag, " rdata_hold"}, mif.resp_rdata, rd);
    last_rdata = got_rd;
  endtask

  initial begin
    logic [31:0] w;
    mif.req_valid = 0; mif.req_we = 0; mif.req_funct3 = 0;
    mif.req_addr = 0; mif.req_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom; mem[i] = w; ref_mem[i] = w;
    end
    mem[4] = 32'h8070F0A5; ref_mem[4] = 32'h8070F0A5;

    repeat (2) @(posedge clk);
    #1;
    check("rst resp_valid", 32'(mif.resp_valid), 0);
    check("rst resp_rdata", mif.resp_rdata, 0);
    check("rst misaligned", 32'(mif.resp_misaligned), 0);
    check("rst mem_we", 32'(mif.mem_we), 0);
    check("rst req_ready", 32'(mif.req_ready), 1);
    rst = 0;

    do_req(0, 3'b000, 32'h10, 0, "LB 0x10");
    check("LB 0x10 const", last_rdata, 32'hFFFFFFA5);
    do_req(0, 3'b100, 32'h11, 0, "LBU 0x11");
    check("LBU 0x11 const", last_rdata, 32'h000000F0);
    do_req(0, 3'b001, 32'h12, 0, "LH 0x12");
    check("LH 0x12 const", last_rdata, 32'hFFFF8070);
    do_req(0, 3'b101, 32'h12, 0, "LHU 0x12");
    check("LHU 0x12 const", last_rdata, 32'h00008070);
    do_req(0, 3'b010, 32'h10, 0, "LW 0x10");
    check("LW 0x10 const", last_rdata, 32'h8070F0A5);
    do_req(1, 3'b000, 32'h13, 32'h12345655, "SB 0x13");
    do_req(0, 3'b010, 32'h10, 0, "LW after SB");
    check("LW after SB const", last_rdata, 32'h5570F0A5);
    do_req(1, 3'b010, 32'h20, 32'hDEADBEEF, "SW 0x20");
    do_req(0, 3'b010, 32'h20, 0, "LW 0x20");
    check("LW 0x20 const", last_rdata, 32'hDEADBEEF);
    do_req(1, 3'b001, 32'h11, 32'h0000BEEF, "SH 0x11");
    do_req(0, 3'b010, 32'h10, 0, "LW after SH");
    do_req(0, 3'b011, 32'h10, 0, "illegal load");
    do_req(1, 3'b101, 32'h10, 32'hFFFFFFFF, "illegal store");
    do_req(0, 3'b010, 32'h13, 0, "LW 0x13");

    // reset during DATA of SB 0x10
    @(posedge clk); #1;
    mif.req_valid = 1; mif.req_we = 1; mif.req_funct3 = 3'b000;
    mif.req_addr = 32'h10; mif.req_wdata = 32'h000000C3;
    @(posedge clk); #1;
    mif.req_valid = 0;
    @(posedge clk); #1;
    check("rstmid in_data mem_we", 32'(mif.mem_we), 1);
    rst = 1; #1;
    check("rstmid mem_we", 32'(mif.mem_we), 0);
    check("rstmid resp_valid", 32'(mif.resp_valid), 0);
    @(posedge clk); #1;
    rst = 0; #1;
    check("rstmid ready_after", 32'(mif.req_ready), 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("rstmid no_resp", 32'(mif.resp_valid), 0);
      check("rstmid no_we", 32'(mif.mem_we), 0);
    end
    do_req(0, 3'b010, 32'h10, 0, "LW after rst");

    for (int t = 0; t < 60; t++)
      do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)),
             $urandom, $sformatf("rand%0d", t));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
